ps2_key_decoder: RTL and testbench

- Converts the raw PS/2 set-2 scancode byte stream from the PS/2 receiver into ordered key events.
- Each event carries ASCII, raw code, make/break and extended flags.
- Tracks break (F0) and extended (E0) prefixes, Shift and Caps Lock state.
- Events are buffered in a parametrised FIFO with a valid/ready output port. Sits between the PS/2 receiver and the display/CPU-side consumer.

---
 rtl/ps2_key_decoder.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the raw PS/2 set-2 scancode byte stream into ordered key events
//   (ASCII, raw code, make/break, extended). Tracks the F0/E0 prefixes,
//   both Shift keys and Caps Lock, and queues events in a FIFO drained
//   through a valid/ready port.
//
//   Optional feature macro: PS2_TYPEMATIC_FILTER_EN
//     When defined, a repeated make of the most recently pushed (held) key is
//     discarded. A break of that key clears it. A different make replaces it.
//
// Ports
//   clk, clrn            clock, synchronous active-low reset
//   in_valid, in_code    one-cycle scancode byte strobe and byte
//   out_valid/out_ready  FIFO head handshake
//   out_ascii/out_code/out_release/out_ext   head event fields
//   shift_held, caps_on  modifier state
//   press_cnt            pushed make events, wraps
//   overflow, ovf_clr    sticky drop flag and its clear
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    input  logic [7:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_ascii,
    output logic [7:0]       out_code,
    output logic             out_release,
    output logic             out_ext,
    output logic             shift_held,
    output logic             caps_on,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow,
    input  logic             ovf_clr
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]      DEPTH_C     = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      CNT_ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE_C   = AW'(1);
    localparam logic [CNT_W-1:0] PRESS_ONE_C = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] ascii;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } event_t;

    // Set-2 code to ASCII; letters case-flip on shift XOR caps, digits shift to symbols.
    function automatic logic [7:0] key_ascii(input logic [7:0] code,
                                             input logic shift, input logic caps);
        logic [7:0] lc;
        logic [7:0] res;
        lc  = 8'h00;
        res = 8'h00;
        case (code)
            8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
            8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
            8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
            default: lc = 8'h00;
        endcase
        if (lc != 8'h00) begin
            res = (shift ^ caps) ? (lc - 8'h20) : lc;
        end else begin
            case (code)
                8'h45: res = shift ? 8'h29 : 8'h30;
                8'h16: res = shift ? 8'h21 : 8'h31;
                8'h1E: res = shift ? 8'h40 : 8'h32;
                8'h26: res = shift ? 8'h23 : 8'h33;
                8'h25: res = shift ? 8'h24 : 8'h34;
                8'h2E: res = shift ? 8'h25 : 8'h35;
                8'h36: res = shift ? 8'h5E : 8'h36;
                8'h3D: res = shift ? 8'h26 : 8'h37;
                8'h3E: res = shift ? 8'h2A : 8'h38;
                8'h46: res = shift ? 8'h28 : 8'h39;
                8'h29: res = 8'h20;
                8'h5A: res = 8'h0D;
                8'h66: res = 8'h08;
                8'h0D: res = 8'h09;
                8'h76: res = 8'h1B;
                default: res = 8'h00;
            endcase
        end
        return res;
    endfunction

    state_t              state_r, state_nxt_s;
    logic                ev_valid_s, ev_release_s, ev_ext_s, is_mod_s;
    logic                push_req_s, push_ok_s, pop_s, full_s, drop_s, filter_hit_s;
    logic                shift_l_r, shift_r_r, shift_held_r, caps_r;
    logic                shift_l_nxt_s, shift_r_nxt_s, caps_nxt_s;
    event_t              ev_entry_s;
    event_t              mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [AW:0]         count_r, count_nxt_s;
    logic                out_valid_r, overflow_r;
    logic [CNT_W-1:0]    press_cnt_r;

    // Prefix FSM state register.
    always_ff @(posedge clk) begin
        if (!clrn) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Prefix FSM next-state; only a valid byte moves it.
    always_comb begin
        state_nxt_s = state_r;
        if (in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_code == 8'hF0)      state_nxt_s = ST_BRK;
                    else if (in_code == 8'hE0) state_nxt_s = ST_EXT;
                    else                       state_nxt_s = ST_IDLE;
                end
                ST_EXT: begin
                    if (in_code == 8'hF0)      state_nxt_s = ST_EXT_BRK;
                    else if (in_code == 8'hE0) state_nxt_s = ST_EXT;
                    else                       state_nxt_s = ST_IDLE;
                end
                ST_BRK:     state_nxt_s = ST_IDLE;
                ST_EXT_BRK: state_nxt_s = ST_IDLE;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Prefix FSM outputs: which byte completes an event, and of what kind.
    always_comb begin
        ev_valid_s   = 1'b0;
        ev_release_s = 1'b0;
        ev_ext_s     = 1'b0;
        if (in_valid) begin
            case (state_r)
                ST_IDLE:    ev_valid_s = (in_code != 8'hF0) && (in_code != 8'hE0);
                ST_EXT: begin
                    ev_valid_s = (in_code != 8'hF0) && (in_code != 8'hE0);
                    ev_ext_s   = 1'b1;
                end
                ST_BRK: begin
                    ev_valid_s   = 1'b1;
                    ev_release_s = 1'b1;
                end
                ST_EXT_BRK: begin
                    ev_valid_s   = 1'b1;
                    ev_release_s = 1'b1;
                    ev_ext_s     = 1'b1;
                end
                default: ev_valid_s = 1'b0;
            endcase
        end else begin
            ev_valid_s = 1'b0;
        end
    end

    // Modifier keys are consumed here and never reach the FIFO.
    assign is_mod_s = !ev_ext_s && ((in_code == 8'h12) || (in_code == 8'h59) || (in_code == 8'h58));

    // ASCII uses the modifier state as it was before this byte.
    assign ev_entry_s = '{ascii: ev_ext_s ? 8'h00 : key_ascii(in_code, shift_held_r, caps_r),
                          code:  in_code,
                          rel:   ev_release_s,
                          ext:   ev_ext_s};

    // Next modifier state from the current event.
    always_comb begin
        shift_l_nxt_s = shift_l_r;
        shift_r_nxt_s = shift_r_r;
        caps_nxt_s    = caps_r;
        if (ev_valid_s && !ev_ext_s) begin
            if (in_code == 8'h12) shift_l_nxt_s = !ev_release_s;
            else                  shift_l_nxt_s = shift_l_r;
            if (in_code == 8'h59) shift_r_nxt_s = !ev_release_s;
            else                  shift_r_nxt_s = shift_r_r;
            if ((in_code == 8'h58) && !ev_release_s) caps_nxt_s = !caps_r;
            else                                     caps_nxt_s = caps_r;
        end else begin
            shift_l_nxt_s = shift_l_r;
            shift_r_nxt_s = shift_r_r;
            caps_nxt_s    = caps_r;
        end
    end

    // Modifier registers.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            shift_l_r    <= 1'b0;
            shift_r_r    <= 1'b0;
            shift_held_r <= 1'b0;
            caps_r       <= 1'b0;
        end else begin
            shift_l_r    <= shift_l_nxt_s;
            shift_r_r    <= shift_r_nxt_s;
            shift_held_r <= shift_l_nxt_s | shift_r_nxt_s;
            caps_r       <= caps_nxt_s;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_vld_r;
    logic       held_ext_r;
    logic [7:0] held_code_r;
    logic       held_match_s;

    assign held_match_s = held_vld_r && (in_code == held_code_r) && (ev_ext_s == held_ext_r);
    assign filter_hit_s = ev_valid_s && !ev_release_s && held_match_s;

    // Held key: set by each pushed make, cleared by its break.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            held_vld_r  <= 1'b0;
            held_ext_r  <= 1'b0;
            held_code_r <= 8'h00;
        end else if (push_ok_s && !ev_release_s) begin
            held_vld_r  <= 1'b1;
            held_ext_r  <= ev_ext_s;
            held_code_r <= in_code;
        end else if (ev_valid_s && ev_release_s && held_match_s) begin
            held_vld_r  <= 1'b0;
        end
    end
`else
    assign filter_hit_s = 1'b0;
`endif

    assign push_req_s = ev_valid_s && !is_mod_s && !filter_hit_s;
    assign pop_s      = out_valid_r && out_ready;
    assign full_s     = (count_r == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok_s  = push_req_s && (!full_s || pop_s);
    assign drop_s     = push_req_s && full_s && !pop_s;

    // FIFO occupancy next value.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers and valid flag.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= ev_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
        end
    end

    // Press counter and sticky overflow; a drop wins over a clear.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            press_cnt_r <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_ok_s && !ev_release_s) press_cnt_r <= press_cnt_r + PRESS_ONE_C;
            if (drop_s)       overflow_r <= 1'b1;
            else if (ovf_clr) overflow_r <= 1'b0;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_ascii   = mem_r[rd_ptr_r].ascii;
    assign out_code    = mem_r[rd_ptr_r].code;
    assign out_release = mem_r[rd_ptr_r].rel;
    assign out_ext     = mem_r[rd_ptr_r].ext;
    assign shift_held  = shift_held_r;
    assign caps_on     = caps_r;
    assign press_cnt   = press_cnt_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed scenarios plus randomized byte
// streams, checked cycle by cycle against a queue-based reference model.
module tb_ps2_key_decoder;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam int TYPEMATIC_CNT = 1;
`else
    localparam int TYPEMATIC_CNT = 3;
`endif

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_code = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_ascii;
    logic [7:0]    out_code;
    logic          out_release;
    logic          out_ext;
    logic          shift_held;
    logic          caps_on;
    logic [CW-1:0] press_cnt;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_ascii(out_ascii),
        .out_code(out_code), .out_release(out_release), .out_ext(out_ext),
        .shift_held(shift_held), .caps_on(caps_on), .press_cnt(press_cnt),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    typedef struct packed {
        logic [7:0] ascii;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;

    ev_t           mq[$];
    bit            m_brk, m_ext, m_sl, m_sr, m_caps, m_ovf, m_held_v, m_held_ext;
    logic [7:0]    m_held_code;
    logic [CW-1:0] m_cnt;
    int            n_cmp = 0;
    int            n_err = 0;

    byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    byte unsigned digit_shift[10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
        8'h26, 8'h2A, 8'h28};
    byte unsigned misc_codes[5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    byte unsigned misc_ascii[5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit sh, input bit cp);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) return (sh ^ cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) return sh ? digit_shift[i] : 8'(8'h30 + i);
        for (int i = 0; i < 5; i++)
            if (misc_codes[i] == c) return misc_ascii[i];
        return 8'h00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_brk = 0; m_ext = 0; m_sl = 0; m_sr = 0; m_caps = 0; m_ovf = 0;
        m_held_v = 0; m_held_ext = 0; m_held_code = 8'h00; m_cnt = '0;
    endtask

    // One clock of the reference: prefixes, modifiers, filter, queue with capacity.
    task automatic model_step(input bit v, input logic [7:0] c, input bit r, input bit clr);
        bit  pop, have_ev, rel, ext, push, drop;
        ev_t e;
        pop = (mq.size() > 0) && r;
        have_ev = 0; rel = 0; ext = 0; push = 0; drop = 0; e = '0;
        if (v) begin
            if (m_brk) begin
                have_ev = 1; rel = 1; ext = m_ext; m_brk = 0; m_ext = 0;
            end else if (c == 8'hF0) begin
                m_brk = 1;
            end else if (c == 8'hE0) begin
                m_ext = 1;
            end else begin
                have_ev = 1; ext = m_ext; m_ext = 0;
            end
        end
        if (have_ev) begin
            e.ascii = ext ? 8'h00 : ref_ascii(c, m_sl | m_sr, m_caps);
            e.code = c; e.rel = rel; e.ext = ext;
            if (!ext && c == 8'h12) m_sl = !rel;
            else if (!ext && c == 8'h59) m_sr = !rel;
            else if (!ext && c == 8'h58) begin
                if (!rel) m_caps = !m_caps;
            end else begin
                push = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (m_held_v && c == m_held_code && ext == m_held_ext) begin
                    if (rel) m_held_v = 0;
                    else     push = 0;
                end
`endif
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(e);
                if (!rel) begin
                    m_cnt = m_cnt + CW'(1);
                    m_held_v = 1; m_held_code = c; m_held_ext = ext;
                end
            end else begin
                drop = 1;
            end
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic compare_all();
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check_eq("shift_held", 32'(shift_held), 32'(m_sl | m_sr));
        check_eq("caps_on", 32'(caps_on), 32'(m_caps));
        check_eq("press_cnt", 32'(press_cnt), 32'(m_cnt));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) begin
            check_eq("head_ascii", 32'(out_ascii), 32'(mq[0].ascii));
            check_eq("head_code", 32'(out_code), 32'(mq[0].code));
            check_eq("head_release", 32'(out_release), 32'(mq[0].rel));
            check_eq("head_ext", 32'(out_ext), 32'(mq[0].ext));
        end
    endtask

    task automatic step(input bit v, input logic [7:0] c, input bit r, input bit clr);
        in_valid = v; in_code = c; out_ready = r; ovf_clr = clr;
        model_step(v, c, r, clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] c, input bit r);
        step(1'b1, c, r, 1'b0);
    endtask

    task automatic idle(input bit r);
        step(1'b0, 8'h00, r, 1'b0);
    endtask

    task automatic do_reset();
        clrn = 1'b0; in_valid = 1'b0; in_code = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ascii", 32'(out_ascii), 32'd0);
        check_eq("rst_code", 32'(out_code), 32'd0);
        check_eq("rst_release", 32'(out_release), 32'd0);
        check_eq("rst_ext", 32'(out_ext), 32'd0);
        check_eq("rst_shift", 32'(shift_held), 32'd0);
        check_eq("rst_caps", 32'(caps_on), 32'd0);
        check_eq("rst_press_cnt", 32'(press_cnt), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        clrn = 1'b1;
    endtask

    function automatic logic [7:0] pick_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 10) return 8'hF0;
        if (r < 16) return 8'hE0;
        if (r < 22) return ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        if (r < 26) return 8'h58;
        if (r < 60) return letter_codes[$urandom_range(0, 25)];
        if (r < 75) return digit_codes[$urandom_range(0, 9)];
        if (r < 82) return misc_codes[$urandom_range(0, 4)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        byte unsigned fill_codes[9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
                                         8'h43, 8'h44};

        // Make then break of 'a'.
        do_reset();
        send(8'h1C, 1'b0);
        check_eq("a_make_ascii", 32'(out_ascii), 32'h61);
        check_eq("a_make_code", 32'(out_code), 32'h1C);
        step(1'b1, 8'hF0, 1'b1, 1'b0);
        send(8'h1C, 1'b0);
        check_eq("a_break_rel", 32'(out_release), 32'd1);
        check_eq("a_break_ascii", 32'(out_ascii), 32'h61);
        check_eq("a_press_cnt", 32'(press_cnt), 32'd1);

        // Shift then Caps Lock both give uppercase.
        do_reset();
        send(8'h12, 1'b1); send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h1C, 1'b1);
        send(8'hF0, 1'b1); send(8'h12, 1'b1); send(8'h58, 1'b1); send(8'hF0, 1'b1);
        send(8'h58, 1'b1); send(8'h1C, 1'b1);
        check_eq("caps_ascii", 32'(out_ascii), 32'h41);
        check_eq("caps_on_set", 32'(caps_on), 32'd1);
        check_eq("shift_released", 32'(shift_held), 32'd0);
        check_eq("mod_press_cnt", 32'(press_cnt), 32'd2);
        idle(1'b1);

        // Extended make and break.
        do_reset();
        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        check_eq("ext_make_ext", 32'(out_ext), 32'd1);
        check_eq("ext_make_ascii", 32'(out_ascii), 32'h00);
        check_eq("ext_make_rel", 32'(out_release), 32'd0);
        step(1'b1, 8'hE0, 1'b1, 1'b0);
        send(8'hF0, 1'b0); send(8'h75, 1'b0);
        check_eq("ext_break_rel", 32'(out_release), 32'd1);
        check_eq("ext_break_ext", 32'(out_ext), 32'd1);
        send(8'h1C, 1'b0);
        idle(1'b1);
        check_eq("idle_after_ext", 32'(out_ext), 32'd0);
        idle(1'b1);

        // Fill past capacity, clear interplay, full push+pop.
        do_reset();
        for (int i = 0; i < 9; i++) send(fill_codes[i], 1'b0);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_press_cnt", 32'(press_cnt), 32'd8);
        check_eq("ovf_head_first", 32'(out_code), 32'h15);
        step(1'b1, 8'h4D, 1'b0, 1'b1);
        check_eq("ovf_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 8'h4B, 1'b1, 1'b0);
        check_eq("full_pushpop_noovf", 32'(overflow), 32'd0);
        check_eq("full_pushpop_cnt", 32'(press_cnt), 32'd9);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        // Typematic repeats.
        do_reset();
        send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
        send(8'hF0, 1'b1); send(8'h1C, 1'b1); idle(1'b1); idle(1'b1);
        check_eq("typematic_cnt", 32'(press_cnt), 32'(TYPEMATIC_CNT));

        // Randomized traffic with alternating drain rates.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit v, r, clr;
            v   = ($urandom_range(0, 3) != 0);
            r   = (((i / 250) % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 31) == 0);
            step(v, pick_code(), r, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
